// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared BCD time types and digit limits for the up and down time counters
package clock_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t SEC_TENS_MAX       = 4'd5;
    localparam bcd_digit_t MIN_TENS_MAX       = 4'd5;
    localparam bcd_digit_t HR_TENS_MAX        = 4'd2;
    localparam bcd_digit_t HR_UNITS_MAX_AT_20 = 4'd3;
    localparam bcd_digit_t DIGIT_MAX          = 4'd9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } timer_state_t;

    // Packed time is {h_tens, h_units, m_tens, m_units, s_tens, s_units}.
    function automatic logic bcd_time_valid(input logic [23:0] t);
        bcd_digit_t ht, hu, mt, mu, st, su;
        logic       ok;
        ht = t[23:20];
        hu = t[19:16];
        mt = t[15:12];
        mu = t[11:8];
        st = t[7:4];
        su = t[3:0];
        ok = (ht <= HR_TENS_MAX) && (hu <= DIGIT_MAX) &&
             (mt <= MIN_TENS_MAX) && (mu <= DIGIT_MAX) &&
             (st <= SEC_TENS_MAX) && (su <= DIGIT_MAX);
        if (ht == HR_TENS_MAX && hu > HR_UNITS_MAX_AT_20) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// rtl/bcd_down_digit.sv - one loadable BCD down-counting digit with wrap-to-MAX borrow
module bcd_down_digit
    import clock_pkg::*;
#(
    parameter bcd_digit_t MAX = DIGIT_MAX
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  bcd_digit_t load_val,
    input  logic       dec,
    output bcd_digit_t q,
    output logic       borrow_out
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (dec) begin
            q <= (q == '0) ? MAX : q - 4'd1;
        end
    end

    assign borrow_out = dec && (q == '0);

endmodule

// File: rtl/countdown_timer_hms.sv
// rtl/countdown_timer_hms.sv - settable HH:MM:SS BCD countdown timer with prescaler, run control and expiry flag
module countdown_timer_hms
    import clock_pkg::*;
#(
    parameter int CLK_DIV = 100_000_000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [23:0] load_bcd,
    input  logic        start,
    input  logic        stop,
    output logic [3:0]  bcd_ht,
    output logic [3:0]  bcd_hu,
    output logic [3:0]  bcd_mt,
    output logic [3:0]  bcd_mu,
    output logic [3:0]  bcd_st,
    output logic [3:0]  bcd_su,
    output logic        running,
    output logic        done,
    output logic        expired,
    output logic        load_err
);

    localparam int            PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    timer_state_t  state, state_next;
    logic [PW-1:0] presc;
    logic          load_ok;
    logic          run_active;
    logic          tick;
    logic          count_zero;
    logic          count_one;
    logic          expire;
    logic [5:0]    dec;
    logic [5:0]    borrow;

    assign count_zero = ({bcd_ht, bcd_hu, bcd_mt, bcd_mu, bcd_st, bcd_su} == 24'h000000);
    assign count_one  = ({bcd_ht, bcd_hu, bcd_mt, bcd_mu, bcd_st, bcd_su} == 24'h000001);

    // Any load (valid or not) and any stop pre-empt counting in this cycle.
    assign load_ok    = load && bcd_time_valid(load_bcd);
    assign run_active = (state == ST_RUN) && !load && !stop;
    assign tick       = run_active && (presc == PRESC_LAST);

    // A borrow out of h_tens would mean wrapping below zero; never call that expiry.
    assign expire     = dec[0] && count_one && !borrow[5];

    assign dec[0]     = tick && !count_zero;
    assign dec[5:1]   = borrow[4:0];

    bcd_down_digit #(.MAX(DIGIT_MAX)) u_su (
        .clk        (clk),
        .rst        (rst),
        .load       (load_ok),
        .load_val   (load_bcd[3:0]),
        .dec        (dec[0]),
        .q          (bcd_su),
        .borrow_out (borrow[0])
    );

    bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_st (
        .clk        (clk),
        .rst        (rst),
        .load       (load_ok),
        .load_val   (load_bcd[7:4]),
        .dec        (dec[1]),
        .q          (bcd_st),
        .borrow_out (borrow[1])
    );

    bcd_down_digit #(.MAX(DIGIT_MAX)) u_mu (
        .clk        (clk),
        .rst        (rst),
        .load       (load_ok),
        .load_val   (load_bcd[11:8]),
        .dec        (dec[2]),
        .q          (bcd_mu),
        .borrow_out (borrow[2])
    );

    bcd_down_digit #(.MAX(MIN_TENS_MAX)) u_mt (
        .clk        (clk),
        .rst        (rst),
        .load       (load_ok),
        .load_val   (load_bcd[15:12]),
        .dec        (dec[3]),
        .q          (bcd_mt),
        .borrow_out (borrow[3])
    );

    // Hours units always wraps to 9 (e.g. 20 -> 19); the 23-hour cap only limits loads.
    bcd_down_digit #(.MAX(DIGIT_MAX)) u_hu (
        .clk        (clk),
        .rst        (rst),
        .load       (load_ok),
        .load_val   (load_bcd[19:16]),
        .dec        (dec[4]),
        .q          (bcd_hu),
        .borrow_out (borrow[4])
    );

    bcd_down_digit #(.MAX(HR_TENS_MAX)) u_ht (
        .clk        (clk),
        .rst        (rst),
        .load       (load_ok),
        .load_val   (load_bcd[23:20]),
        .dec        (dec[5]),
        .q          (bcd_ht),
        .borrow_out (borrow[5])
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (load) begin
            if (load_ok) begin
                state_next = ST_IDLE;
            end
        end else if (stop) begin
            state_next = ST_IDLE;
        end else if (start && state == ST_IDLE) begin
            if (!count_zero) begin
                state_next = ST_RUN;
            end
        end else if (expire) begin
            state_next = ST_IDLE;
        end
    end

    // Prescaler only advances while counting, so stop/resume keeps the second phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc    <= '0;
            done     <= 1'b0;
            expired  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            done     <= expire;
            load_err <= load && !load_ok;
            if (load_ok) begin
                presc   <= '0;
                expired <= 1'b0;
            end else begin
                if (expire) begin
                    expired <= 1'b1;
                end
                if (run_active) begin
                    presc <= tick ? '0 : presc + 1'b1;
                end
            end
        end
    end

    assign running = (state == ST_RUN);

endmodule

// File: tb/tb_countdown_timer_hms.sv
// tb/tb_countdown_timer_hms.sv - scoreboard bench for the HH:MM:SS countdown timer
module tb_countdown_timer_hms;

    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [23:0] load_bcd = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [3:0]  bcd_ht, bcd_hu, bcd_mt, bcd_mu, bcd_st, bcd_su;
    logic        running, done, expired, load_err;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;

    typedef struct {
        logic [23:0] digits;
        int          cycles;
    } exp_t;

    exp_t sb[$];

    countdown_timer_hms #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_bcd (load_bcd),
        .start    (start),
        .stop     (stop),
        .bcd_ht   (bcd_ht),
        .bcd_hu   (bcd_hu),
        .bcd_mt   (bcd_mt),
        .bcd_mu   (bcd_mu),
        .bcd_st   (bcd_st),
        .bcd_su   (bcd_su),
        .running  (running),
        .done     (done),
        .expired  (expired),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    function automatic logic [23:0] cur();
        return {bcd_ht, bcd_hu, bcd_mt, bcd_mu, bcd_st, bcd_su};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [23:0] v);
        load_bcd = v;
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
    endtask

    task automatic wait_change(output int cyc, output logic [23:0] val);
        logic [23:0] prev;
        prev = cur();
        cyc  = -1;
        val  = prev;
        for (int i = 1; i <= 4 * CLK_DIV; i++) begin
            step(1);
            if (cur() !== prev) begin
                cyc = i;
                val = cur();
                break;
            end
        end
    endtask

    task automatic drain(input string name);
        exp_t        e;
        int          cyc;
        logic [23:0] val;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_change(cyc, val);
            n_cmp++;
            if (val !== e.digits || cyc != e.cycles) begin
                n_err++;
                $display("FAIL %s: got %06h after %0d cycles, expected %06h after %0d cycles",
                         name, val, cyc, e.digits, e.cycles);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        n_cmp++; if (cur() !== 24'h000000) begin n_err++; $display("FAIL reset_digits: got %06h expected 000000", cur()); end
        n_cmp++; if ({running, done, expired, load_err} !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b expected 0000", {running, done, expired, load_err}); end
        rst = 1'b0;
        step(1);
        n_cmp++; if (cur() !== 24'h000000 || running !== 1'b0) begin n_err++; $display("FAIL post_reset_idle: got %06h run=%b expected 000000 run=0", cur(), running); end
    endtask

    task automatic test_countdown();
        int d0;
        do_load(24'h000005);
        n_cmp++; if (cur() !== 24'h000005 || running !== 1'b0) begin n_err++; $display("FAIL load_5: got %06h run=%b expected 000005 run=0", cur(), running); end
        d0 = done_cnt;
        do_start();
        n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL start_running: got %b expected 1", running); end
        for (int v = 4; v >= 0; v--) sb.push_back('{digits: 24'(v), cycles: CLK_DIV});
        drain("countdown_step");
        n_cmp++; if ({done, running, expired} !== 3'b101) begin n_err++; $display("FAIL zero_flags: got done,run,exp=%b expected 101", {done, running, expired}); end
        step(1);
        n_cmp++; if (done !== 1'b0 || expired !== 1'b1) begin n_err++; $display("FAIL done_one_cycle: got done=%b exp=%b expected done=0 exp=1", done, expired); end
        step(2 * CLK_DIV);
        n_cmp++; if (done_cnt - d0 != 1 || cur() !== 24'h000000) begin n_err++; $display("FAIL done_count: got %0d pulses digits %06h expected 1 pulse 000000", done_cnt - d0, cur()); end
    endtask

    task automatic test_borrow_chain();
        do_load(24'h010000);
        n_cmp++; if (expired !== 1'b0) begin n_err++; $display("FAIL load_clears_expired: got %b expected 0", expired); end
        do_start();
        sb.push_back('{digits: 24'h005959, cycles: CLK_DIV});
        drain("borrow_chain");
        n_cmp++; if (expired !== 1'b0 || running !== 1'b1) begin n_err++; $display("FAIL borrow_flags: got exp=%b run=%b expected exp=0 run=1", expired, running); end
        do_stop();
    endtask

    task automatic test_load_err();
        do_load(24'h240000);
        n_cmp++; if (load_err !== 1'b1 || cur() !== 24'h005959 || running !== 1'b0) begin n_err++; $display("FAIL load_err_hours: got err=%b %06h run=%b expected err=1 005959 run=0", load_err, cur(), running); end
        step(1);
        n_cmp++; if (load_err !== 1'b0) begin n_err++; $display("FAIL load_err_pulse: got %b expected 0", load_err); end
        do_start();
        do_load(24'h006000);
        n_cmp++; if (load_err !== 1'b1 || cur() !== 24'h005959 || running !== 1'b1) begin n_err++; $display("FAIL load_err_minutes: got err=%b %06h run=%b expected err=1 005959 run=1", load_err, cur(), running); end
        do_stop();
    endtask

    task automatic test_stop_resume();
        do_load(24'h000010);
        do_start();
        sb.push_back('{digits: 24'h000009, cycles: CLK_DIV});
        drain("pre_stop_tick");
        step(2);
        stop = 1'b1;
        step(10);
        stop = 1'b0;
        n_cmp++; if (cur() !== 24'h000009 || running !== 1'b0) begin n_err++; $display("FAIL paused: got %06h run=%b expected 000009 run=0", cur(), running); end
        do_start();
        sb.push_back('{digits: 24'h000008, cycles: 2});
        drain("resume_phase");
        do_stop();
    endtask

    task automatic test_stop_on_tick();
        do_load(24'h000004);
        do_start();
        step(CLK_DIV - 1);
        do_stop();
        n_cmp++; if (cur() !== 24'h000004 || running !== 1'b0) begin n_err++; $display("FAIL stop_drops_tick: got %06h run=%b expected 000004 run=0", cur(), running); end
        do_start();
        sb.push_back('{digits: 24'h000003, cycles: 1});
        drain("resume_ticks_first");
        do_stop();
    endtask

    task automatic test_load_stop_tick();
        int d0;
        do_load(24'h000006);
        do_start();
        step(CLK_DIV - 1);
        load_bcd = 24'h000003;
        load = 1'b1;
        stop = 1'b1;
        step(1);
        load = 1'b0;
        stop = 1'b0;
        n_cmp++; if (cur() !== 24'h000003 || running !== 1'b0) begin n_err++; $display("FAIL load_over_tick: got %06h run=%b expected 000003 run=0", cur(), running); end
        d0 = done_cnt;
        do_start();
        for (int v = 2; v >= 0; v--) sb.push_back('{digits: 24'(v), cycles: CLK_DIV});
        drain("second_countdown");
        n_cmp++; if (done !== 1'b1 || expired !== 1'b1) begin n_err++; $display("FAIL second_expiry: got done=%b exp=%b expected 1 1", done, expired); end
        step(1);
        do_start();
        n_cmp++; if (running !== 1'b0 || cur() !== 24'h000000 || expired !== 1'b1) begin n_err++; $display("FAIL start_at_zero: got run=%b %06h exp=%b expected run=0 000000 exp=1", running, cur(), expired); end
        step(2 * CLK_DIV);
        n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL second_done_count: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_async_reset();
        int d0;
        do_load(24'h000050);
        do_start();
        step(CLK_DIV + 1);
        d0 = done_cnt;
        rst = 1'b1;
        #2;
        n_cmp++; if (cur() !== 24'h000000 || {running, done, expired, load_err} !== 4'b0000) begin n_err++; $display("FAIL async_reset: got %06h flags=%b expected 000000 0000", cur(), {running, done, expired, load_err}); end
        step(2);
        rst = 1'b0;
        step(3 * CLK_DIV);
        n_cmp++; if (done_cnt != d0 || running !== 1'b0 || cur() !== 24'h000000) begin n_err++; $display("FAIL reset_no_done: got pulses=%0d run=%b %06h expected 0 0 000000", done_cnt - d0, running, cur()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_countdown();
        test_borrow_chain();
        test_load_err();
        test_stop_resume();
        test_stop_on_tick();
        test_load_stop_tick();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
